// File: rtl/cp0_ctrl_unit.sv
// rtl/cp0_ctrl_unit.sv - MIPS CP0 control unit: Count/Compare timer, Status/Cause/EPC/BadVAddr, exceptions, ERET
// Optional: define CP0_WR_BYPASS_EN to forward a same-cycle MTC0 write to the MFC0 read port.
module cp0_ctrl_unit #(
   parameter int          HW_INT_N   = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] PRID_VAL   = 32'h004C0102,
   parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [4:0]          waddr_i,
   input  logic [31:0]         wdata_i,
   input  logic [4:0]          raddr_i,
   output logic [31:0]         rdata_o,
   input  logic [HW_INT_N-1:0] int_i,
   input  logic                exc_valid_i,
   input  logic [4:0]          exc_code_i,
   input  logic                eret_i,
   input  logic                in_delayslot_i,
   input  logic [31:0]         exc_pc_i,
   input  logic [31:0]         bad_addr_i,
   output logic                int_req_o,
   output logic                timer_int_o,
   output logic [31:0]         count_o,
   output logic [31:0]         compare_o,
   output logic [31:0]         status_o,
   output logic [31:0]         cause_o,
   output logic [31:0]         epc_o,
   output logic [31:0]         badvaddr_o
);

   localparam int          PW           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
   localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;
   localparam logic [31:0] STATUS_RST   = 32'h00400000;

   logic [PW-1:0] presc;
   logic [31:0]   count, compare, status, cause, epc, badvaddr;
   logic          timer_int;
   logic [5:0]    hw_ip;
   logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic [31:0]   cur;

   assign wr_count   = we_i && (waddr_i == 5'd9);
   assign wr_compare = we_i && (waddr_i == 5'd11);
   assign wr_status  = we_i && (waddr_i == 5'd12);
   assign wr_cause   = we_i && (waddr_i == 5'd13);
   assign wr_epc     = we_i && (waddr_i == 5'd14);

   // Unused hardware lines read as 0 in Cause.IP.
   always_comb begin
      hw_ip = '0;
      hw_ip[HW_INT_N-1:0] = int_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc     <= '0;
         count     <= '0;
         compare   <= '0;
         status    <= STATUS_RST;
         cause     <= '0;
         epc       <= '0;
         badvaddr  <= '0;
         timer_int <= 1'b0;
      end else begin
         if (wr_count) begin
            count <= wdata_i;
            presc <= '0;
         end else if (presc == PRESC_LAST) begin
            count <= count + 32'd1;
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end

         if (wr_compare) begin
            compare   <= wdata_i;
            timer_int <= 1'b0;
         end else if (count == compare && compare != 32'd0) begin
            timer_int <= 1'b1;
         end

         cause[15:10] <= {timer_int | hw_ip[5], hw_ip[4:0]};
         if (wr_cause)
            cause[9:8] <= wdata_i[9:8];
         if (wr_status)
            status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
         if (wr_epc && !exc_valid_i)
            epc <= wdata_i;

         // Later assignments override earlier ones: exception > ERET > MTC0 on EXL.
         if (eret_i && !exc_valid_i)
            status[1] <= 1'b0;
         if (exc_valid_i) begin
            if (!status[1]) begin
               epc       <= in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
               cause[31] <= in_delayslot_i;
            end
            status[1]  <= 1'b1;
            cause[6:2] <= exc_code_i;
            if (exc_code_i == 5'd4 || exc_code_i == 5'd5)
               badvaddr <= bad_addr_i;
         end
      end
   end

`ifdef CP0_WR_BYPASS_EN
   function automatic logic [31:0] wmask(input logic [4:0] a);
      case (a)
         5'd9, 5'd11, 5'd14: wmask = 32'hFFFFFFFF;
         5'd12:              wmask = STATUS_WMASK;
         5'd13:              wmask = CAUSE_WMASK;
         default:            wmask = 32'h0;
      endcase
   endfunction
`endif

   always_comb begin
      cur = '0;
      case (raddr_i)
         5'd8:    cur = badvaddr;
         5'd9:    cur = count;
         5'd11:   cur = compare;
         5'd12:   cur = status;
         5'd13:   cur = cause;
         5'd14:   cur = epc;
         5'd15:   cur = PRID_VAL;
         5'd16:   cur = CONFIG_VAL;
         default: cur = '0;
      endcase
`ifdef CP0_WR_BYPASS_EN
      if (we_i && waddr_i == raddr_i)
         cur = (cur & ~wmask(raddr_i)) | (wdata_i & wmask(raddr_i));
`endif
      rdata_o = rst ? cur : 32'h0;
   end

   assign int_req_o   = status[0] & ~status[1] & |(cause[15:8] & status[15:8]);
   assign timer_int_o = timer_int;
   assign count_o     = count;
   assign compare_o   = compare;
   assign status_o    = status;
   assign cause_o     = cause;
   assign epc_o       = epc;
   assign badvaddr_o  = badvaddr;

endmodule

// File: tb/tb_cp0_ctrl_unit.sv
// tb/tb_cp0_ctrl_unit.sv - directed and randomized bench for cp0_ctrl_unit against a behavioural model
module tb_cp0_ctrl_unit;

   localparam int COUNT_DIV = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr = '0;
   logic [5:0]  int_i = '0;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_code = '0;
   logic        eret = 1'b0;
   logic        ds = 1'b0;
   logic [31:0] exc_pc = '0;
   logic [31:0] bad_addr = '0;
   logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
   logic        int_req_o, timer_int_o;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
   logic        m_timer;
   int          m_div;

   always #5 clk = ~clk;

   cp0_ctrl_unit #(.HW_INT_N(6), .COUNT_DIV(COUNT_DIV)) dut (
      .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rdata_o), .int_i(int_i),
      .exc_valid_i(exc_valid), .exc_code_i(exc_code), .eret_i(eret),
      .in_delayslot_i(ds), .exc_pc_i(exc_pc), .bad_addr_i(bad_addr),
      .int_req_o(int_req_o), .timer_int_o(timer_int_o),
      .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
      .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

`ifdef CP0_WR_BYPASS_EN
   function automatic logic [31:0] m_mask(input logic [4:0] a);
      if (a == 9 || a == 11 || a == 14) return 32'hFFFFFFFF;
      if (a == 12) return 32'h0000FF03;
      if (a == 13) return 32'h00000300;
      return 32'h0;
   endfunction
`endif

   function automatic logic [31:0] m_read();
      logic [31:0] v;
      v = 32'h0;
      if (raddr == 8)  v = m_bad;
      if (raddr == 9)  v = m_count;
      if (raddr == 11) v = m_compare;
      if (raddr == 12) v = m_status;
      if (raddr == 13) v = m_cause;
      if (raddr == 14) v = m_epc;
      if (raddr == 15) v = 32'h004C0102;
      if (raddr == 16) v = 32'h00008000;
`ifdef CP0_WR_BYPASS_EN
      if (we && waddr == raddr) v = (v & ~m_mask(raddr)) | (wdata & m_mask(raddr));
`endif
      return rst ? v : 32'h0;
   endfunction

   function automatic logic m_intreq();
      return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic m_step();
      logic old_timer, old_exl;
      old_timer = m_timer;
      old_exl = m_status[1];
      if (!rst) begin
         m_count = 0; m_compare = 0; m_status = 32'h00400000; m_cause = 0;
         m_epc = 0; m_bad = 0; m_timer = 0; m_div = 0;
         return;
      end
      if (we && waddr == 11) m_timer = 0;
      else if (m_count == m_compare && m_compare != 0) m_timer = 1;
      if (we && waddr == 9) begin
         m_count = wdata;
         m_div = 0;
      end else begin
         m_div = m_div + 1;
         if (m_div == COUNT_DIV) begin
            m_div = 0;
            m_count = m_count + 1;
         end
      end
      if (we && waddr == 11) m_compare = wdata;
      m_cause[15:10] = {old_timer | int_i[5], int_i[4:0]};
      if (we && waddr == 13) m_cause[9:8] = wdata[9:8];
      if (we && waddr == 12) m_status = (m_status & 32'hFFFF00FC) | (wdata & 32'h0000FF03);
      if (eret && !exc_valid) m_status[1] = 1'b0;
      if (exc_valid) begin
         if (!old_exl) begin
            m_epc = ds ? exc_pc - 4 : exc_pc;
            m_cause[31] = ds;
         end
         m_status[1] = 1'b1;
         m_cause[6:2] = exc_code;
         if (exc_code == 4 || exc_code == 5) m_bad = bad_addr;
      end else if (we && waddr == 14) begin
         m_epc = wdata;
      end
   endtask

   task automatic tick();
      #1;
      check("rdata_pre", rdata_o, m_read());
      check("int_req_pre", {31'b0, int_req_o}, {31'b0, m_intreq()});
      m_step();
      @(posedge clk);
      #1;
      check("count", count_o, m_count);
      check("compare", compare_o, m_compare);
      check("status", status_o, m_status);
      check("cause", cause_o, m_cause);
      check("epc", epc_o, m_epc);
      check("badvaddr", badvaddr_o, m_bad);
      check("timer", {31'b0, timer_int_o}, {31'b0, m_timer});
   endtask

   initial begin
      int waited;
      m_count = 0; m_compare = 0; m_status = 32'h00400000; m_cause = 0;
      m_epc = 0; m_bad = 0; m_timer = 0; m_div = 0;
      @(negedge clk);

      // Reset and release
      tick(); tick();
      check("rst_status", status_o, 32'h00400000);
      check("rst_count", count_o, 32'h0);
      rst = 1'b1;
      raddr = 5'd15;
      #1 check("prid_read", rdata_o, 32'h004C0102);
      for (int i = 0; i < 10; i++) tick();
      check("count_after_10", count_o, 32'd5);

      // Timer match, IP7 and interrupt request
      we = 1'b1; waddr = 5'd11; wdata = 32'h20; tick();
      waddr = 5'd9; wdata = 32'h1E; tick();
      waddr = 5'd12; wdata = 32'h00008001; tick();
      we = 1'b0; raddr = 5'd13;
      waited = 0;
      while (timer_int_o !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("timer_set", {31'b0, timer_int_o}, 32'd1);
      tick();
      check("cause_ip7", {31'b0, cause_o[15]}, 32'd1);
      check("int_req_timer", {31'b0, int_req_o}, 32'd1);
      we = 1'b1; waddr = 5'd11; wdata = 32'h40; tick();
      we = 1'b0;
      check("timer_clear", {31'b0, timer_int_o}, 32'd0);

      // Exception entry in a delay slot, then nested exception, then ERET
      exc_valid = 1'b1; exc_code = 5'd4; ds = 1'b1; exc_pc = 32'hBFC00104; bad_addr = 32'h1233;
      tick();
      exc_valid = 1'b0; ds = 1'b0;
      check("exc_epc", epc_o, 32'hBFC00100);
      check("exc_bd", {31'b0, cause_o[31]}, 32'd1);
      check("exc_code", {27'b0, cause_o[6:2]}, 32'd4);
      check("exc_badva", badvaddr_o, 32'h1233);
      check("exc_exl", {31'b0, status_o[1]}, 32'd1);
      check("exc_intreq", {31'b0, int_req_o}, 32'd0);
      exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h80000010; tick();
      exc_valid = 1'b0;
      check("nest_epc", epc_o, 32'hBFC00100);
      check("nest_code", {27'b0, cause_o[6:2]}, 32'd8);
      eret = 1'b1; tick();
      eret = 1'b0;
      check("eret_exl", {31'b0, status_o[1]}, 32'd0);

      // Exception beats ERET and MTC0 EPC in the same cycle
      exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h80000200; eret = 1'b1;
      we = 1'b1; waddr = 5'd14; wdata = 32'h1234; tick();
      exc_valid = 1'b0; eret = 1'b0;
      check("prio_epc", epc_o, 32'h80000200);
      check("prio_exl", {31'b0, status_o[1]}, 32'd1);
      tick();
      we = 1'b0;
      check("epc_write", epc_o, 32'h1234);

      // Reset mid-count
      we = 1'b1; waddr = 5'd9; wdata = 32'h77; tick();
      we = 1'b0; raddr = 5'd9;
      check("count_77", count_o, 32'h77);
      rst = 1'b0; tick();
      check("rst_mid_count", count_o, 32'h0);
      check("rst_mid_timer", {31'b0, timer_int_o}, 32'd0);
      check("rst_mid_rdata", rdata_o, 32'h0);
      rst = 1'b1;

      // Same-cycle write/read of Status
      raddr = 5'd12; we = 1'b1; waddr = 5'd12; wdata = 32'hFFFFFFFF;
      #1;
`ifdef CP0_WR_BYPASS_EN
      check("bypass_status", rdata_o, 32'h0040FF03);
`else
      check("nobypass_status", rdata_o, 32'h00400000);
`endif
      tick();
      we = 1'b0;
      check("status_masked", status_o, 32'h0040FF03);
      eret = 1'b1; tick(); eret = 1'b0;

      // Randomized traffic; MTC0 and exceptions kept in separate cycles
      for (int i = 0; i < 400; i++) begin
         logic [4:0] regs [8];
         regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
         rst = ($urandom_range(0, 99) >= 2);
         int_i = 6'($urandom);
         raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : regs[$urandom_range(0, 7)];
         exc_valid = ($urandom_range(0, 9) == 0);
         exc_code = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
         ds = 1'($urandom);
         exc_pc = $urandom;
         bad_addr = $urandom;
         eret = ($urandom_range(0, 9) == 0);
         we = !exc_valid && ($urandom_range(0, 9) < 3);
         waddr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : regs[$urandom_range(0, 7)];
         wdata = $urandom;
         if (we && waddr == 5'd9 && $urandom_range(0, 1) == 0) wdata = m_compare - 32'd2;
         if ($urandom_range(0, 1) == 0) raddr = waddr;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
